quad_decoder_filtered: RTL and testbench
========================================

QUAD_DECODER_FILTERED -- requirements
Module: quad_decoder_filtered

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; port names are clk and reset.
REQ-002 The block SHALL have parameter FILTER_LEN, default 3, meaning consecutive stable cycles required to accept a channel change (legal range 1..15).
REQ-003 The block SHALL have parameter COUNT_W, default 32, meaning encoderCount width.
REQ-004 Ports SHALL be exactly as follows:
- clk  in  1  system clock
- reset  in  1  async active-high reset
- sigA  in  1  encoder channel A, asynchronous
- sigB  in  1  encoder channel B, asynchronous
- clear  in  1  synchronous clear of count and error state
- encoderCount  out  COUNT_W  signed two's-complement position
- stepPulse  out  1  one-cycle pulse per accepted count step
- dirOut  out  1  direction of last accepted step; 1 = up
- errorFlag  out  1  sticky illegal-transition flag
- errorCount  out  8  saturating illegal-transition count

Function
REQ-005 Each channel SHALL pass through a 2-flop synchronizer, then a glitch filter.
REQ-006 Filter per channel:
- counter increments on each edge where the synchronized sample differs from the filtered value
- counter resets to 0 on any edge where they match
- filtered value takes the sample on the FILTER_LEN-th consecutive differing edge; counter then resets
REQ-007 Decode compares previous filtered {A,B} with current filtered {A,B} on every edge in RUN:
- 00->10->11->01->00: +1, dirOut=1
- reverse sequence: -1, dirOut=0
- no change: no action
- both bits changed: illegal
REQ-008 A legal step SHALL update encoderCount, dirOut and stepPulse on the edge after the filtered change. Latency is FILTER_LEN+3 edges from an input change, counting the first edge after the change as edge 1.
REQ-009 An illegal step SHALL leave encoderCount and dirOut unchanged, set errorFlag, and increment errorCount with saturation at 255.
REQ-010 encoderCount SHALL wrap modulo 2^COUNT_W: max positive +1 gives most negative; 0 -1 gives all-ones.
REQ-011 clear SHALL zero encoderCount, errorFlag and errorCount and suppress stepPulse in that cycle. clear has priority over a simultaneous step or illegal event, and that event is discarded.
REQ-012 A pulse on either channel shorter than FILTER_LEN synchronized cycles SHALL produce no step and no error.
REQ-013 State machine states:
- INIT: entered on reset; held for 2 edges after reset release; no decode, no pulses, count held at 0
- RUN: entered on the 3rd edge after release, which loads filtered {A,B} and previous {A,B} from the synchronized samples without decoding
REQ-014 RUN SHALL be exited only by reset.

Reset
REQ-015 While reset is high, all of the following SHALL be 0 and the state SHALL be INIT: synchronizers, filter counters, filtered values, previous state, encoderCount, stepPulse, dirOut, errorFlag, errorCount.
REQ-016 Reset asserted mid-step SHALL discard the step; after release, no spurious step or error is produced regardless of the sigA/sigB levels.

Structure
REQ-017 Package quad_pkg SHALL hold the state enum (INIT, RUN), the 2-bit phase typedef, and the ERR_MAX=255 constant.
REQ-018 Sub-module glitch_filter (synchronizer + filter, parameter FILTER_LEN) SHALL be instantiated once per channel. Decode, counter and error logic reside in the top.

Verification
REQ-019 Forward 4 full cycles, 10-cycle phases, FILTER_LEN=3 -> encoderCount=16, 16 stepPulses, dirOut=1, first count change on edge 6 after the first input change.
REQ-020 From count 0, 1 reverse step -> encoderCount=0xFFFFFFFF and dirOut=0. Separately, preload 0x7FFFFFFF via forward steps, then 1 forward step -> 0x80000000.
REQ-021 2-cycle glitch on sigA while stable -> no stepPulse and no count change. The same glitch held 3 cycles -> exactly one step.
REQ-022 sigA and sigB toggled on the same cycle from 00 -> errorFlag=1, errorCount=1, count unchanged. 300 such events -> errorCount=255.
REQ-023 clear asserted on the cycle a legal step would occur -> encoderCount=0, no stepPulse, errorFlag=0.
REQ-024 Reset released with sigA=sigB=1 -> INIT for 2 edges, then RUN with encoderCount=0 and no error. Reset pulsed mid-rotation -> all outputs return to 0.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared types and constants for the filtered quadrature decoder.
// Phase ordering helper maps {A,B} onto its position in the forward cycle.
package quad_pkg;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    typedef logic [1:0] phase_t;

    localparam int ERR_MAX = 255;

    // Forward order is 00 -> 10 -> 11 -> 01, so position deltas give direction
    function automatic logic [1:0] phase_pos(input phase_t p);
        logic [1:0] pos;
        pos = 2'd0;
        unique case (p)
            2'b00: pos = 2'd0;
            2'b10: pos = 2'd1;
            2'b11: pos = 2'd2;
            2'b01: pos = 2'd3;
        endcase
        return pos;
    endfunction

endpackage

// File: rtl/glitch_filter.sv
// Two-flop synchronizer followed by a consecutive-cycle stability filter.
// load forces the filtered value to the synchronized sample.
module glitch_filter
    import quad_pkg::*;
#(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic en,
    input  logic load,
    output logic sample,
    output logic dout
);

    localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

    logic       sync1;
    logic [3:0] cnt;

    // Bring the asynchronous channel into the clock domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= 1'b0;
            sample <= 1'b0;
        end else begin
            sync1  <= din;
            sample <= sync1;
        end
    end

    // Accept a new level only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= 4'd0;
            dout <= 1'b0;
        end else if (load) begin
            cnt  <= 4'd0;
            dout <= sample;
        end else if (!en) begin
            cnt <= 4'd0;
        end else if (sample != dout) begin
            if (cnt == CNT_LAST) begin
                cnt  <= 4'd0;
                dout <= sample;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end else begin
            cnt <= 4'd0;
        end
    end

endmodule

// File: rtl/quad_decoder_filtered.sv
// Quadrature decoder with per-channel glitch filtering, signed position
// counter and sticky/saturating illegal-transition tracking.
module quad_decoder_filtered
    import quad_pkg::*;
#(
    parameter int FILTER_LEN = 3,
    parameter int COUNT_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sigA,
    input  logic               sigB,
    input  logic               clear,
    output logic [COUNT_W-1:0] encoderCount,
    output logic               stepPulse,
    output logic               dirOut,
    output logic               errorFlag,
    output logic [7:0]         errorCount
);

    state_t     state;
    logic [1:0] init_cnt;
    phase_t     prev;
    phase_t     cur;
    phase_t     samp;
    logic       load;
    logic       run;
    logic [1:0] delta;

    assign load  = (state == INIT) && (init_cnt == 2'd2);
    assign run   = (state == RUN);
    assign delta = phase_pos(cur) - phase_pos(prev);

    glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk    (clk),
        .reset  (reset),
        .din    (sigA),
        .en     (run),
        .load   (load),
        .sample (samp[1]),
        .dout   (cur[1])
    );

    glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk    (clk),
        .reset  (reset),
        .din    (sigB),
        .en     (run),
        .load   (load),
        .sample (samp[0]),
        .dout   (cur[0])
    );

    // Startup sequencing, step decode, position and error bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= INIT;
            init_cnt     <= 2'd0;
            prev         <= 2'b00;
            encoderCount <= '0;
            stepPulse    <= 1'b0;
            dirOut       <= 1'b0;
            errorFlag    <= 1'b0;
            errorCount   <= 8'd0;
        end else begin
            stepPulse <= 1'b0;
            unique case (state)
                INIT: begin
                    if (load) begin
                        state <= RUN;
                        prev  <= samp;
                    end else begin
                        init_cnt <= init_cnt + 2'd1;
                    end
                end
                RUN: begin
                    prev <= cur;
                    if (clear) begin
                        encoderCount <= '0;
                        errorFlag    <= 1'b0;
                        errorCount   <= 8'd0;
                    end else begin
                        unique case (delta)
                            2'd1: begin
                                encoderCount <= encoderCount + COUNT_W'(1);
                                dirOut       <= 1'b1;
                                stepPulse    <= 1'b1;
                            end
                            2'd3: begin
                                encoderCount <= encoderCount - COUNT_W'(1);
                                dirOut       <= 1'b0;
                                stepPulse    <= 1'b1;
                            end
                            2'd2: begin
                                errorFlag <= 1'b1;
                                if (errorCount != 8'(ERR_MAX))
                                    errorCount <= errorCount + 8'd1;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quad_decoder_filtered.sv
// Directed self-checking bench for quad_decoder_filtered.
// Table of settled segments plus hand sequences for timing corners.
module tb_quad_decoder_filtered;
    import quad_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        sigA;
    logic        sigB;
    logic        clear;
    logic        clear2;
    logic [31:0] encoderCount;
    logic        stepPulse;
    logic        dirOut;
    logic        errorFlag;
    logic [7:0]  errorCount;
    logic [3:0]  cnt2;
    logic        pulse2;
    logic        dir2;
    logic        flag2;
    logic [7:0]  ecnt2;

    int pass_cnt = 0;
    int total    = 0;
    int pulses   = 0;

    always #5 clk = ~clk;

    quad_decoder_filtered #(.FILTER_LEN(3), .COUNT_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .sigA         (sigA),
        .sigB         (sigB),
        .clear        (clear),
        .encoderCount (encoderCount),
        .stepPulse    (stepPulse),
        .dirOut       (dirOut),
        .errorFlag    (errorFlag),
        .errorCount   (errorCount)
    );

    quad_decoder_filtered #(.FILTER_LEN(1), .COUNT_W(4)) dut2 (
        .clk          (clk),
        .reset        (reset),
        .sigA         (sigA),
        .sigB         (sigB),
        .clear        (clear2),
        .encoderCount (cnt2),
        .stepPulse    (pulse2),
        .dirOut       (dir2),
        .errorFlag    (flag2),
        .errorCount   (ecnt2)
    );

    always @(posedge clk) begin
        if (stepPulse === 1'b1)
            pulses <= pulses + 1;
    end

    typedef struct {
        logic        a;
        logic        b;
        logic        clr;
        int          hold;
        logic [31:0] cnt;
        logic        dir;
        logic        flg;
        logic [7:0]  ecnt;
    } vec_t;

    vec_t tbl[12];
    logic [1:0] fwd[4];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic hold(input logic a, input logic b, input int n);
        sigA = a;
        sigB = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        int first;
        int pb;
        logic [31:0] base;

        fwd[0] = 2'b10;
        fwd[1] = 2'b11;
        fwd[2] = 2'b01;
        fwd[3] = 2'b00;

        tbl[0]  = '{1'b0, 1'b1, 1'b0, 10, 32'd1, 1'b1, 1'b0, 8'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 10, 32'd2, 1'b1, 1'b0, 8'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 10, 32'd3, 1'b1, 1'b0, 8'd0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 10, 32'd4, 1'b1, 1'b0, 8'd0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 10, 32'd3, 1'b0, 1'b0, 8'd0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 10, 32'd2, 1'b0, 1'b0, 8'd0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 10, 32'd1, 1'b0, 1'b0, 8'd0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 10, 32'd2, 1'b1, 1'b0, 8'd0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 10, 32'd2, 1'b1, 1'b1, 8'd1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 10, 32'd2, 1'b1, 1'b1, 8'd2};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1,  32'd0, 1'b1, 1'b0, 8'd0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 10, 32'd1, 1'b1, 1'b0, 8'd0};

        reset  = 1'b1;
        sigA   = 1'b1;
        sigB   = 1'b1;
        clear  = 1'b0;
        clear2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_count", encoderCount, 32'd0);
        chk("rst_pulse", 32'(stepPulse), 32'd0);
        chk("rst_dir", 32'(dirOut), 32'd0);
        chk("rst_flag", 32'(errorFlag), 32'd0);
        chk("rst_ecnt", 32'(errorCount), 32'd0);
        chk("rst_state", 32'(dut.state), 32'(INIT));

        // Release with both channels high
        reset = 1'b0;
        @(posedge clk); #1;
        chk("init_edge1", 32'(dut.state), 32'(INIT));
        @(posedge clk); #1;
        chk("init_edge2", 32'(dut.state), 32'(INIT));
        @(posedge clk); #1;
        chk("run_edge3", 32'(dut.state), 32'(RUN));
        @(negedge clk);
        repeat (8) @(negedge clk);
        chk("rel11_count", encoderCount, 32'd0);
        chk("rel11_flag", 32'(errorFlag), 32'd0);

        for (int i = 0; i < 12; i++) begin
            sigA  = tbl[i].a;
            sigB  = tbl[i].b;
            clear = tbl[i].clr;
            repeat (tbl[i].hold) @(negedge clk);
            clear = 1'b0;
            chk($sformatf("tbl%0d_count", i), encoderCount, tbl[i].cnt);
            chk($sformatf("tbl%0d_dir", i), 32'(dirOut), 32'(tbl[i].dir));
            chk($sformatf("tbl%0d_flag", i), 32'(errorFlag), 32'(tbl[i].flg));
            chk($sformatf("tbl%0d_ecnt", i), 32'(errorCount), 32'(tbl[i].ecnt));
        end

        // Four forward cycles with latency measurement on the first step
        hold(1'b0, 1'b0, 10);
        pulse_clear();
        pb    = pulses;
        sigA  = 1'b1;
        sigB  = 1'b0;
        first = 0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            if (first == 0 && encoderCount != 32'd0)
                first = e;
        end
        @(negedge clk);
        for (int k = 1; k < 16; k++)
            hold(fwd[k % 4][1], fwd[k % 4][0], 10);
        chk("fwd_latency", 32'(first), 32'd6);
        chk("fwd_count", encoderCount, 32'd16);
        chk("fwd_pulses", 32'(pulses - pb), 32'd16);
        chk("fwd_dir", 32'(dirOut), 32'd1);

        // Narrow counter: preload max positive then wrap to most negative
        clear2 = 1'b1;
        @(negedge clk);
        clear2 = 1'b0;
        for (int k = 0; k < 7; k++)
            hold(fwd[k % 4][1], fwd[k % 4][0], 10);
        chk("w4_max_pos", 32'(cnt2), 32'd7);
        chk("fwd23_count", encoderCount, 32'd23);
        hold(1'b0, 1'b0, 10);
        chk("w4_wrap_neg", 32'(cnt2), 32'd8);

        // Reverse step from zero wraps to all-ones
        pulse_clear();
        hold(1'b0, 1'b1, 10);
        chk("rev_count", encoderCount, 32'hFFFF_FFFF);
        chk("rev_dir", 32'(dirOut), 32'd0);

        // Short glitch is rejected, sustained change is accepted
        hold(1'b0, 1'b0, 10);
        base = encoderCount;
        pb   = pulses;
        sigA = 1'b1;
        repeat (2) @(negedge clk);
        sigA = 1'b0;
        repeat (10) @(negedge clk);
        chk("glitch_count", encoderCount, base);
        chk("glitch_pulses", 32'(pulses - pb), 32'd0);
        chk("glitch_flag", 32'(errorFlag), 32'd0);
        hold(1'b1, 1'b0, 10);
        chk("held_count", encoderCount, base + 32'd1);
        chk("held_pulses", 32'(pulses - pb), 32'd1);

        // Illegal double transitions and saturation
        hold(1'b0, 1'b0, 10);
        pulse_clear();
        base = encoderCount;
        hold(1'b1, 1'b1, 6);
        chk("ill1_flag", 32'(errorFlag), 32'd1);
        chk("ill1_ecnt", 32'(errorCount), 32'd1);
        chk("ill1_count", encoderCount, base);
        for (int n = 2; n <= 300; n++)
            hold(n[0], n[0], 6);
        chk("sat_ecnt", 32'(errorCount), 32'd255);
        chk("sat_flag", 32'(errorFlag), 32'd1);
        chk("sat_count", encoderCount, base);

        // clear landing on the decode edge discards the step
        hold(1'b1, 1'b0, 10);
        chk("pre_clr_count", encoderCount, base + 32'd1);
        pb   = pulses;
        sigA = 1'b1;
        sigB = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (10) @(negedge clk);
        chk("clrstep_count", encoderCount, 32'd0);
        chk("clrstep_pulses", 32'(pulses - pb), 32'd0);
        chk("clrstep_flag", 32'(errorFlag), 32'd0);
        chk("clrstep_ecnt", 32'(errorCount), 32'd0);

        // Reset in the middle of a step
        hold(1'b0, 1'b1, 10);
        chk("pre_rst_count", encoderCount, 32'd1);
        sigA = 1'b0;
        sigB = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_count", encoderCount, 32'd0);
        chk("mid_rst_dir", 32'(dirOut), 32'd0);
        chk("mid_rst_pulse", 32'(stepPulse), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        pb    = pulses;
        repeat (12) @(negedge clk);
        chk("post_rst_count", encoderCount, 32'd0);
        chk("post_rst_flag", 32'(errorFlag), 32'd0);
        chk("post_rst_pulses", 32'(pulses - pb), 32'd0);
        chk("post_rst_state", 32'(dut.state), 32'(RUN));

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
